// File: rtl/block_color_buffer.sv
// Block-colour RAM filled from a 3-wire serial link (sclk/mosi/cs_n) and read
// by the VGA pixel path through a registered, reset-able read port.
module block_color_buffer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [5:0]        rd_color,
    output logic              busy,
    output logic              err
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, WRITE, FILL_COLOR, FILLING, IGNORE
    } state_t;

    logic [2:0] sclk_sync_reg;
    logic [1:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic       cs_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_reg <= 3'b000;
            cs_sync_reg   <= 2'b11;
            mosi_sync_reg <= 2'b00;
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
            cs_sync_reg   <= {cs_sync_reg[0], cs_n};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
            cs_prev_reg   <= cs_sync_reg[1];
        end
    end

    logic sclk_rise;
    logic cs_high;
    logic cs_fall;
    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign cs_high   = cs_sync_reg[1];
    assign cs_fall   = cs_prev_reg & ~cs_sync_reg[1];

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       byte_valid_reg;

    // shift_reg holds the completed byte during the cycle byte_valid_reg is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg      <= 8'h00;
            bit_cnt_reg    <= 3'd0;
            byte_valid_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (cs_high) begin
                bit_cnt_reg <= 3'd0;
            end else if (sclk_rise) begin
                shift_reg      <= {shift_reg[6:0], mosi_sync_reg[1]};
                bit_cnt_reg    <= bit_cnt_reg + 3'd1;
                byte_valid_reg <= (bit_cnt_reg == 3'd7);
            end
        end
    end

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [ADDR_W-1:0] fptr_reg, fptr_next;
    logic [5:0]        fill_color_reg, fill_color_next;
    logic              err_reg, err_next;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [5:0]        wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wptr_reg       <= '0;
            fptr_reg       <= '0;
            fill_color_reg <= 6'd0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wptr_reg       <= wptr_next;
            fptr_reg       <= fptr_next;
            fill_color_reg <= fill_color_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wptr_next       = wptr_reg;
        fptr_next       = fptr_reg;
        fill_color_next = fill_color_reg;
        err_next        = 1'b0;
        we              = 1'b0;
        waddr           = wptr_reg;
        wdata           = shift_reg[5:0];
        // Only a fill survives cs_n going high; everything else drops to IDLE.
        if (cs_high && state_reg != FILLING) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (cs_fall) state_next = CMD;
                CMD: if (byte_valid_reg) begin
                    case (shift_reg)
                        8'h01:   state_next = ADDR_HI;
                        8'h02:   state_next = WRITE;
                        8'h03:   state_next = FILL_COLOR;
                        default: begin
                            state_next = IGNORE;
                            err_next   = 1'b1;
                        end
                    endcase
                end
                ADDR_HI: if (byte_valid_reg) begin
                    wptr_next[ADDR_W-1:8] = shift_reg[ADDR_W-9:0];
                    state_next            = ADDR_LO;
                end
                ADDR_LO: if (byte_valid_reg) begin
                    wptr_next[7:0] = shift_reg;
                    state_next     = WRITE;
                end
                WRITE: if (byte_valid_reg) begin
                    we        = 1'b1;
                    wptr_next = wptr_reg + ADDR_W'(1);
                end
                FILL_COLOR: if (byte_valid_reg) begin
                    fill_color_next = shift_reg[5:0];
                    fptr_next       = '0;
                    state_next      = FILLING;
                end
                FILLING: begin
                    we        = 1'b1;
                    waddr     = fptr_reg;
                    wdata     = fill_color_reg;
                    fptr_next = fptr_reg + ADDR_W'(1);
                    err_next  = byte_valid_reg;
                    if (fptr_reg == {ADDR_W{1'b1}}) begin
                        wptr_next  = '0;
                        state_next = cs_high ? IDLE : IGNORE;
                    end
                end
                IGNORE:  state_next = IGNORE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state_reg == FILLING);
    assign err  = err_reg;

    logic [5:0] mem [DEPTH];

    // Gating with rst_n makes a reset abort a fill before its next write lands.
    always_ff @(posedge clk) begin
        if (we && rst_n) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_color <= 6'd0;
        else        rd_color <= mem[rd_addr];
    end
endmodule

// File: tb/tb_block_color_buffer.sv
// Self-checking bench for block_color_buffer: table vectors, hand sequences for
// abort/fill/reset, and random transactions checked against a memory model.
module tb_block_color_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic [10:0] rd_addr = 11'd0;
    logic [5:0]  rd_color;
    logic        busy;
    logic        err;

    block_color_buffer #(.ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .rd_addr(rd_addr), .rd_color(rd_color), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int busy_cycles = 0;

    always @(posedge clk) begin
        if (err)  err_cnt++;
        if (busy) busy_cycles++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Reference model: -1 marks an entry whose content is unknown.
    int ref_mem [2048];
    int m_wptr;
    logic [7:0] txn_b [16];
    int txn_n;
    int exp_err;

    typedef struct {
        int n;
        logic [5:0][7:0] b;
        int nchk;
        logic [2:0][10:0] ca;
        logic [2:0][5:0] cv;
        int e;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int n, int b0, int b1, int b2, int b3, int b4, int b5,
                                int nchk, int a0, int v0, int a1, int v1, int a2, int v2, int e);
        vec_t v;
        v.n = n;
        v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2);
        v.b[3] = 8'(b3); v.b[4] = 8'(b4); v.b[5] = 8'(b5);
        v.nchk = nchk;
        v.ca[0] = 11'(a0); v.ca[1] = 11'(a1); v.ca[2] = 11'(a2);
        v.cv[0] = 6'(v0);  v.cv[1] = 6'(v1);  v.cv[2] = 6'(v2);
        v.e = e;
        return v;
    endfunction

    task automatic check(string name, int actual, int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(logic [7:0] b, int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            tick(5);
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_end();
        tick(6);
        cs_n = 1'b1;
        tick(10);
    endtask

    task automatic m_write(logic [7:0] b);
        ref_mem[m_wptr] = int'(b) % 64;
        m_wptr = (m_wptr + 1) % 2048;
    endtask

    task automatic model_txn();
        exp_err = 0;
        case (txn_b[0])
            8'h01: if (txn_n >= 3) begin
                m_wptr = (int'(txn_b[1]) % 8) * 256 + int'(txn_b[2]);
                for (int i = 3; i < txn_n; i++) m_write(txn_b[i]);
            end
            8'h02: for (int i = 1; i < txn_n; i++) m_write(txn_b[i]);
            8'h03: if (txn_n >= 2) begin
                for (int a = 0; a < 2048; a++) ref_mem[a] = int'(txn_b[1]) % 64;
                m_wptr = 0;
                exp_err = txn_n - 2;
            end
            default: exp_err = 1;
        endcase
    endtask

    task automatic run_txn(string name);
        int e0;
        e0 = err_cnt;
        cs_begin();
        for (int i = 0; i < txn_n; i++) send_bits(txn_b[i], 8);
        cs_end();
        model_txn();
        check($sformatf("%s_err", name), err_cnt - e0, exp_err);
    endtask

    task automatic check_rd(int a, int v, string name);
        rd_addr = 11'(a);
        tick(1);
        check(name, int'(rd_color), v);
    endtask

    // New address every cycle, so each compare also pins the read latency to 1.
    task automatic sweep(string name);
        for (int a = 0; a < 2048; a++) begin
            rd_addr = 11'(a);
            tick(1);
            if (ref_mem[a] >= 0)
                check($sformatf("%s_rd[%0h]", name, a), int'(rd_color), ref_mem[a]);
        end
    endtask

    initial begin
        int e0;
        int b0;
        int g;
        for (int a = 0; a < 2048; a++) ref_mem[a] = -1;
        m_wptr = 0;

        vecs[0] = mk(2, 'h02, 'h15, 0, 0, 0, 0,       1, 'h000, 'h15, 0, 0, 0, 0, 0);
        vecs[1] = mk(6, 'h01, 'h03, 'hFE, 'h3F, 'h2A, 'h11,
                     3, 'h3FE, 'h3F, 'h3FF, 'h2A, 'h400, 'h11, 0);
        vecs[2] = mk(5, 'h01, 'h07, 'hFF, 'h05, 'h06, 0,
                     2, 'h7FF, 'h05, 'h000, 'h06, 0, 0, 0);
        vecs[3] = mk(2, 'h02, 'hEB, 0, 0, 0, 0,       1, 'h001, 'h2B, 0, 0, 0, 0, 0);
        vecs[4] = mk(3, 'h7E, 'h22, 'h33, 0, 0, 0,    1, 'h001, 'h2B, 0, 0, 0, 0, 1);
        vecs[5] = mk(2, 'h02, 'h3C, 0, 0, 0, 0,       2, 'h002, 'h3C, 'h001, 'h2B, 0, 0, 0);

        // Reset with random pins
        rst_n = 1'b0;
        sclk = 1'($urandom); mosi = 1'($urandom); cs_n = 1'($urandom);
        rd_addr = 11'($urandom);
        tick(2);
        check("reset_rd_color", int'(rd_color), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(4);

        // Table-driven transactions
        for (int v = 0; v < 6; v++) begin
            e0 = err_cnt;
            txn_n = vecs[v].n;
            for (int i = 0; i < txn_n; i++) txn_b[i] = vecs[v].b[i];
            cs_begin();
            for (int i = 0; i < txn_n; i++) send_bits(txn_b[i], 8);
            cs_end();
            model_txn();
            check($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].e);
            for (int c = 0; c < vecs[v].nchk; c++)
                check_rd(int'(vecs[v].ca[c]), int'(vecs[v].cv[c]), $sformatf("vec%0d_rd%0d", v, c));
        end

        // Abort a data byte after 5 bits: nothing written, wptr unchanged
        e0 = err_cnt;
        cs_begin();
        send_bits(8'h02, 8);
        send_bits(8'hFF, 5);
        cs_end();
        check("abort_err", err_cnt - e0, 0);
        txn_b[0] = 8'h02; txn_b[1] = 8'h1A; txn_n = 2;
        run_txn("after_abort");
        check_rd(3, 'h1A, "after_abort_rd");

        // Random transactions against the model
        for (int t = 0; t < 25; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                txn_b[0] = 8'h01;
                txn_b[1] = 8'($urandom);
                txn_b[2] = 8'($urandom);
                txn_n = 3 + $urandom_range(0, 4);
            end else if (kind == 3) begin
                txn_b[0] = 8'($urandom_range(4, 255));
                txn_n = 1 + $urandom_range(0, 2);
            end else begin
                txn_b[0] = 8'h02;
                txn_n = 1 + $urandom_range(1, 5);
            end
            for (int i = (kind == 0) ? 3 : 1; i < txn_n; i++) txn_b[i] = 8'($urandom);
            run_txn($sformatf("rand%0d", t));
        end
        sweep("rand");

        // Fill with a stray byte during the fill
        b0 = busy_cycles;
        txn_b[0] = 8'h03; txn_b[1] = 8'h09; txn_b[2] = 8'h55; txn_n = 3;
        run_txn("fill");
        g = 0;
        while (busy && g < 5000) begin
            tick(1);
            g++;
        end
        check("fill_done", int'(busy), 0);
        check("fill_busy_len", busy_cycles - b0, 2048);
        sweep("fill");
        txn_b[0] = 8'h02; txn_b[1] = 8'h2F; txn_n = 2;
        run_txn("post_fill");
        check_rd(0, 'h2F, "post_fill_wptr0");

        // Reset after 100 fill writes
        b0 = busy_cycles;
        cs_begin();
        send_bits(8'h03, 8);
        send_bits(8'h2A, 8);
        g = 0;
        while (busy_cycles - b0 < 100 && g < 5000) begin
            tick(1);
            g++;
        end
        check("rst_fill_reached", busy_cycles - b0, 100);
        rst_n = 1'b0;
        cs_n = 1'b1;
        tick(1);
        check("rst_fill_busy", int'(busy), 0);
        check("rst_fill_rd_color", int'(rd_color), 0);
        rst_n = 1'b1;
        tick(4);
        for (int a = 0; a < 100; a++) ref_mem[a] = 'h2A;
        m_wptr = 0;
        sweep("rst_fill");
        txn_b[0] = 8'h02; txn_b[1] = 8'h01; txn_n = 2;
        run_txn("after_rst");
        check_rd(0, 'h01, "after_rst_rd0");
        check_rd(1, 'h2A, "after_rst_rd1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
